// File: rtl/rr_grant_pkg.sv
// Shared types and legal parameter bounds for the round-robin grant FSM.
package rr_grant_pkg;

    // Controller state: waiting for a request, or a requester owns the resource.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Legal parameter ranges, checked at elaboration by the top level.
    localparam int N_MIN    = 2;
    localparam int N_MAX    = 16;
    localparam int HOLD_MAX = 256;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate req so ptr lands on bit 0,
// take the lowest set bit, then rotate the result back to a real index.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win_onehot,
    output logic [IW-1:0] win_idx,
    output logic          win_valid
);

    logic [N-1:0]  rot;
    logic [IW-1:0] pe_idx;

    // Rotate request vector so that index ptr becomes position 0.
    always_comb begin
        logic [IW:0] src;
        rot = '0;
        for (int i = 0; i < N; i++) begin
            src = (IW+1)'(i) + {1'b0, ptr};
            if (src >= (IW+1)'(N)) begin
                src = src - (IW+1)'(N);
            end
            rot[i] = req[src[IW-1:0]];
        end
    end

    // Priority-encode the rotated vector: lowest set position wins.
    always_comb begin
        pe_idx    = '0;
        win_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pe_idx    = IW'(i);
                win_valid = 1'b1;
            end
        end
    end

    // Rotate the winning position back by ptr (mod N) and build the one-hot.
    always_comb begin
        logic [IW:0] sum;
        sum = {1'b0, pe_idx} + {1'b0, ptr};
        if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
        end
        win_idx    = sum[IW-1:0];
        win_onehot = '0;
        if (win_valid) begin
            win_onehot[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_grant_fsm.sv
// Round-robin arbiter for one shared resource. A requester keeps ownership
// while its request stays high, for at most MAX_HOLD cycles, after which the
// grant is revoked and priority rotates past it. All outputs are registered.
//
// Handshake: req[i] is a level request (valid); grant[i] is the registered
// acceptance (ready). Requester i owns the resource in every cycle where
// grant[i]=1; dropping req[i] is the release and takes effect at the next
// edge. A new owner is never granted in the same cycle a previous grant ends,
// so consecutive ownerships are always separated by one cycle with grant=0.
module rr_grant_fsm
    import rr_grant_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IW       = $clog2(N),
    parameter int HW       = $clog2(MAX_HOLD + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_id,
    output logic          busy,
    output logic          timeout,
    output state_t        state_dbg
);

    // Reject out-of-range configurations at elaboration time.
    if (N < N_MIN || N > N_MAX) begin : g_bad_n
        $error("rr_grant_fsm: N out of range");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > HOLD_MAX) begin : g_bad_hold
        $error("rr_grant_fsm: MAX_HOLD out of range");
    end

    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [IW-1:0] LAST_ID   = IW'(N - 1);

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [N-1:0]  grant_nxt;
    logic [IW-1:0] grant_id_nxt;
    logic          busy_nxt;
    logic          timeout_nxt;

    logic [N-1:0]  pick_onehot;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;
    logic [IW-1:0] ptr_after_owner;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req        (req),
        .ptr        (ptr),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx),
        .win_valid  (pick_valid)
    );

    assign state_dbg = state;

    // Priority after an ownership ends: the index just past the owner.
    assign ptr_after_owner = (grant_id == LAST_ID) ? '0 : grant_id + IW'(1);

    // State, pointer, hold counter and output registers; reset wins over all.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            grant    <= grant_nxt;
            grant_id <= grant_id_nxt;
            busy     <= busy_nxt;
            timeout  <= timeout_nxt;
        end
    end

    // Next-state and next-output decode; grant_id doubles as the owner index.
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        hold_nxt     = hold_cnt;
        grant_nxt    = grant;
        grant_id_nxt = grant_id;
        busy_nxt     = busy;
        timeout_nxt  = 1'b0;

        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt    = GRANT;
                    grant_nxt    = pick_onehot;
                    grant_id_nxt = pick_idx;
                    busy_nxt     = 1'b1;
                    hold_nxt     = '0;
                end else begin
                    grant_nxt    = '0;
                    grant_id_nxt = '0;
                    busy_nxt     = 1'b0;
                end
            end
            GRANT: begin
                if (!req[grant_id]) begin
                    // Owner released voluntarily.
                    state_nxt    = IDLE;
                    grant_nxt    = '0;
                    grant_id_nxt = '0;
                    busy_nxt     = 1'b0;
                    ptr_nxt      = ptr_after_owner;
                end else if (hold_cnt == HOLD_LAST) begin
                    // Owner used its full slot; revoke and flag it.
                    state_nxt    = IDLE;
                    grant_nxt    = '0;
                    grant_id_nxt = '0;
                    busy_nxt     = 1'b0;
                    ptr_nxt      = ptr_after_owner;
                    timeout_nxt  = 1'b1;
                end else begin
                    hold_nxt = hold_cnt + HW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
